// File: rtl/ssd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ssd_pkg
// Description : Shared constants and helpers for the SSD AXI4-Lite register
//               block: register indices, response codes, hex-to-segment
//               decode and byte-lane write merge.
// Revision    : 1.0 - initial release
// ============================================================================
package ssd_pkg;

    // Register indices as seen on address bits [3:2]
    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_VALUE   = 2'd1;
    localparam logic [1:0] REG_DIV     = 2'd2;
    localparam logic [1:0] REG_SCRATCH = 2'd3;

    // AXI response code; this block never signals an error
    localparam logic [1:0] RESP_OKAY   = 2'b00;

    // Hex digit to active-high segment pattern {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        seg = 7'h00;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

    // Merge write data into an existing word, one byte lane per strobe bit
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wstrb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) begin
                res[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ssd_refresh_mux.sv
`default_nettype none
// ============================================================================
// Module      : ssd_refresh_mux
// Description : Two-digit seven-segment refresh multiplexer. A free-running
//               counter alternates the digit select every DIV+1 cycles and
//               the segment pattern for the newly selected nibble is
//               registered on the same edge as the select.
// Revision    : 1.0 - initial release
// ============================================================================
module ssd_refresh_mux
    import ssd_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [7:0]  value_i,
    input  logic [31:0] div_i,
    output logic [6:0]  seg_o,
    output logic        sel_o
);

    logic [31:0] cnt_q, cnt_d;
    logic        sel_q, sel_d;
    logic [6:0]  seg_q, seg_d;

    // Next-state: wrap and toggle once the counter reaches the divider.
    // Using >= (not ==) means a DIV shrunk below the current count still
    // wraps on the very next cycle instead of running to 2^32.
    always_comb begin
        cnt_d = cnt_q + 32'd1;
        sel_d = sel_q;
        if (cnt_q >= div_i) begin
            cnt_d = 32'd0;
            sel_d = ~sel_q;
        end
        // Decode from the upcoming select so segments and select move together
        seg_d = 7'h00;
        if (en_i) begin
            seg_d = hex_to_seg(sel_d ? value_i[7:4] : value_i[3:0]);
        end
    end

    // Counter, digit select and registered segment outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= 32'd0;
            sel_q <= 1'b0;
            seg_q <= 7'h00;
        end else begin
            cnt_q <= cnt_d;
            sel_q <= sel_d;
            seg_q <= seg_d;
        end
    end

    assign seg_o = seg_q;
    assign sel_o = sel_q;

endmodule
`default_nettype wire

// File: rtl/ssd_axil_regs.sv
`default_nettype none
// ============================================================================
// Module      : ssd_axil_regs
// Description : AXI4-Lite slave with four 32-bit R/W registers (CTRL, VALUE,
//               DIV, SCRATCH) driving a two-digit multiplexed seven-segment
//               display through ssd_refresh_mux. Only a 32-bit data bus is
//               supported.
// Revision    : 1.0 - initial release
// ============================================================================
module ssd_axil_regs
    import ssd_pkg::*;
#(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 4,
    parameter logic [31:0] DIV_RESET          = 32'd99_999
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESET,
    // Write address / data / response
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    // Read address / data
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    // Display pins
    output logic [6:0]                        ssd_seg,
    output logic                              ssd_sel
);

    logic [31:0] ctrl_q, ctrl_d;
    logic [31:0] value_q, value_d;
    logic [31:0] div_q, div_d;
    logic [31:0] scratch_q, scratch_d;

    logic        bvalid_q, bvalid_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;

    logic        w_wr_accept;
    logic        w_rd_accept;
    logic [1:0]  w_wr_idx;
    logic [1:0]  w_rd_idx;
    logic [31:0] w_rd_mux;

    // Both write channels are taken in the same cycle and only while no
    // response is outstanding; a lone AW or W simply waits.
    assign w_wr_accept = S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q & ~S_AXI_ARESET;
    assign w_rd_accept = S_AXI_ARVALID & ~rvalid_q & ~S_AXI_ARESET;

    assign w_wr_idx = S_AXI_AWADDR[3:2];
    assign w_rd_idx = S_AXI_ARADDR[3:2];

    assign S_AXI_AWREADY = w_wr_accept;
    assign S_AXI_WREADY  = w_wr_accept;
    assign S_AXI_ARREADY = w_rd_accept;

    // Read mux; sampled from the current registers so a read accepted on
    // the same edge as a write returns the pre-write value
    always_comb begin
        w_rd_mux = 32'd0;
        case (w_rd_idx)
            REG_CTRL:    w_rd_mux = ctrl_q;
            REG_VALUE:   w_rd_mux = value_q;
            REG_DIV:     w_rd_mux = div_q;
            REG_SCRATCH: w_rd_mux = scratch_q;
            default:     w_rd_mux = 32'd0;
        endcase
    end

    // Register file next-state: byte-lane merge into the addressed register
    always_comb begin
        ctrl_d    = ctrl_q;
        value_d   = value_q;
        div_d     = div_q;
        scratch_d = scratch_q;
        if (w_wr_accept) begin
            case (w_wr_idx)
                REG_CTRL:    ctrl_d    = apply_wstrb(ctrl_q,    S_AXI_WDATA, S_AXI_WSTRB);
                REG_VALUE:   value_d   = apply_wstrb(value_q,   S_AXI_WDATA, S_AXI_WSTRB);
                REG_DIV:     div_d     = apply_wstrb(div_q,     S_AXI_WDATA, S_AXI_WSTRB);
                REG_SCRATCH: scratch_d = apply_wstrb(scratch_q, S_AXI_WDATA, S_AXI_WSTRB);
                default:     ctrl_d    = ctrl_q;
            endcase
        end
    end

    // Response channel next-state: valid set on accept, held until ready
    always_comb begin
        bvalid_d = bvalid_q;
        if (bvalid_q && S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end
        if (w_wr_accept) begin
            bvalid_d = 1'b1;
        end

        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
        if (w_rd_accept) begin
            rvalid_d = 1'b1;
            rdata_d  = w_rd_mux;
        end
    end

    // Register file and handshake state
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            ctrl_q    <= 32'd0;
            value_q   <= 32'd0;
            div_q     <= DIV_RESET;
            scratch_q <= 32'd0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            ctrl_q    <= ctrl_d;
            value_q   <= value_d;
            div_q     <= div_d;
            scratch_q <= scratch_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    assign S_AXI_BVALID = bvalid_q;
    assign S_AXI_BRESP  = RESP_OKAY;
    assign S_AXI_RVALID = rvalid_q;
    assign S_AXI_RRESP  = RESP_OKAY;
    assign S_AXI_RDATA  = rdata_q;

    ssd_refresh_mux u_refresh (
        .clk_i   (S_AXI_ACLK),
        .rst_i   (S_AXI_ARESET),
        .en_i    (ctrl_q[0]),
        .value_i (value_q[7:0]),
        .div_i   (div_q),
        .seg_o   (ssd_seg),
        .sel_o   (ssd_sel)
    );

    // Sub-word address bits and spare register bits carry no function
    logic w_unused;
    assign w_unused = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                        ctrl_q[31:1], value_q[31:8]};

endmodule
`default_nettype wire

// File: tb/tb_ssd_axil_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_ssd_axil_regs
// Description : Self-checking bench for ssd_axil_regs: vector table of
//               write/readback pairs, hand sequences for handshake, display
//               and reset corners, and random register traffic against a
//               reference register array and display rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ssd_axil_regs;

    localparam logic [31:0] DIV_RST = 32'd99_999;
    localparam logic [6:0] SEG_TAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F,
                                            7'h66, 7'h6D, 7'h7D, 7'h07,
                                            7'h7F, 7'h6F, 7'h77, 7'h7C,
                                            7'h39, 7'h5E, 7'h79, 7'h71};

    logic        clk = 1'b0;
    logic        S_AXI_ARESET;
    logic [3:0]  S_AXI_AWADDR;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [3:0]  S_AXI_ARADDR;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic [6:0]  ssd_seg;
    logic        ssd_sel;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_regs [4];

    always #5 clk = ~clk;

    ssd_axil_regs #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (4),
        .DIV_RESET          (DIV_RST)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESET  (S_AXI_ARESET),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .ssd_seg       (ssd_seg),
        .ssd_sel       (ssd_sel)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference register write: each strobed byte lane takes the new data
    task automatic model_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        w = m_regs[a[3:2]];
        for (int b = 0; b < 4; b++) begin
            if (s[b]) w[8*b +: 8] = d[8*b +: 8];
        end
        m_regs[a[3:2]] = w;
    endtask

    task automatic model_reset();
        m_regs[0] = 32'd0;
        m_regs[1] = 32'd0;
        m_regs[2] = DIV_RST;
        m_regs[3] = 32'd0;
    endtask

    // All tasks start and end 1 time unit after a rising edge
    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
        n = 0;
        @(negedge clk);
        while (!(S_AXI_AWREADY && S_AXI_WREADY) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("wr_accept_in_time", 32'(n < 50), 32'd1);
        @(posedge clk); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        model_write(a, d, s);
        chk("wr_bvalid_latency", 32'(S_AXI_BVALID), 32'd1);
        chk("wr_bresp", 32'(S_AXI_BRESP), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
        int n;
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
        n = 0;
        @(negedge clk);
        while (!S_AXI_ARREADY && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rd_accept_in_time", 32'(n < 50), 32'd1);
        @(posedge clk); #1;
        S_AXI_ARVALID = 1'b0;
        chk("rd_rvalid_latency", 32'(S_AXI_RVALID), 32'd1);
        chk("rd_rresp", 32'(S_AXI_RRESP), 32'd0);
        d = S_AXI_RDATA;
        @(posedge clk); #1;
    endtask

    // Display rules: each digit held DIV+1 cycles, segments show the
    // selected nibble when enabled and are dark otherwise
    task automatic check_display(input int cycles);
        logic        prev;
        int          run;
        int          toggles;
        logic [3:0]  nib;
        logic [6:0]  exp;
        prev = ssd_sel; run = 0; toggles = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (ssd_sel !== prev) begin
                if (toggles > 0) chk("sel_period", run, m_regs[2] + 32'd1);
                toggles++;
                run = 1;
                prev = ssd_sel;
            end else begin
                run++;
            end
            nib = ssd_sel ? m_regs[1][7:4] : m_regs[1][3:0];
            exp = m_regs[0][0] ? SEG_TAB[nib] : 7'h00;
            chk("seg_pattern", 32'(ssd_seg), 32'(exp));
        end
        chk("sel_toggling", 32'(toggles >= 2), 32'd1);
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [3:0]  ra;

        vecs[0] = '{4'h0, 32'h0000_0001, 4'hF, 32'h0000_0001};
        vecs[1] = '{4'h4, 32'h0000_0002, 4'hF, 32'h0000_0002};
        vecs[2] = '{4'h8, 32'h0000_0003, 4'hF, 32'h0000_0003};
        vecs[3] = '{4'hC, 32'h0000_0004, 4'hF, 32'h0000_0004};
        vecs[4] = '{4'hC, 32'hFFFF_FFFF, 4'hF, 32'hFFFF_FFFF};
        vecs[5] = '{4'hC, 32'h0000_00AB, 4'h1, 32'hFFFF_FFAB};
        vecs[6] = '{4'hC, 32'h1234_5678, 4'h6, 32'hFF34_56AB};
        vecs[7] = '{4'h4, 32'hA5A5_A5A5, 4'h8, 32'hA500_0002};
        vecs[8] = '{4'h0, 32'hFFFF_FFFF, 4'h0, 32'h0000_0001};

        S_AXI_ARESET = 1'b1;
        S_AXI_AWADDR = 4'h0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = 32'h0; S_AXI_WSTRB = 4'h0; S_AXI_WVALID = 1'b0;
        S_AXI_BREADY = 1'b1;
        S_AXI_ARADDR = 4'h0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1 S_AXI_ARESET = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_awready", 32'(S_AXI_AWREADY), 32'd0);
        chk("rst_bvalid",  32'(S_AXI_BVALID),  32'd0);
        chk("rst_rvalid",  32'(S_AXI_RVALID),  32'd0);
        chk("rst_rdata",   S_AXI_RDATA,        32'd0);
        chk("rst_seg",     32'(ssd_seg),       32'd0);
        chk("rst_sel",     32'(ssd_sel),       32'd0);
        @(posedge clk); #1;
        axi_read(4'h8, d); chk("rst_div", d, DIV_RST);
        axi_read(4'h0, d); chk("rst_ctrl", d, 32'd0);

        // Vector table: write then read back
        for (int i = 0; i < 9; i++) begin
            axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb);
            axi_read(vecs[i].addr, d);
            chk($sformatf("vec%0d_readback", i), d, vecs[i].exp);
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i * 4), d);
            chk($sformatf("readall_%0d", i), d, m_regs[i]);
        end

        // AW ahead of W, then a long-held response blocking the next write
        S_AXI_AWADDR = 4'hC; S_AXI_WDATA = 32'h0BAD_F00D; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("aw_alone_awready", 32'(S_AXI_AWREADY), 32'd0);
            chk("aw_alone_wready",  32'(S_AXI_WREADY),  32'd0);
        end
        @(posedge clk); #1 S_AXI_WVALID = 1'b1;
        @(negedge clk);
        chk("aw_w_awready", 32'(S_AXI_AWREADY), 32'd1);
        @(posedge clk); #1;
        model_write(4'hC, 32'h0BAD_F00D, 4'hF);
        S_AXI_AWADDR = 4'h0; S_AXI_WDATA = 32'h0000_0001;
        repeat (5) begin
            @(negedge clk);
            chk("bvalid_hold", 32'(S_AXI_BVALID), 32'd1);
            chk("blocked_awready", 32'(S_AXI_AWREADY), 32'd0);
        end
        @(posedge clk); #1 S_AXI_BREADY = 1'b1;
        @(negedge clk);
        chk("bvalid_until_sampled", 32'(S_AXI_BVALID), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bvalid_cleared", 32'(S_AXI_BVALID), 32'd0);
        chk("second_awready", 32'(S_AXI_AWREADY), 32'd1);
        @(posedge clk); #1;
        model_write(4'h0, 32'h0000_0001, 4'hF);
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        chk("second_bvalid", 32'(S_AXI_BVALID), 32'd1);
        @(posedge clk); #1;
        axi_read(4'hC, d); chk("aw_early_readback", d, 32'h0BAD_F00D);

        // Display with EN=1, VALUE=0x3A, DIV=3
        axi_write(4'h4, 32'h0000_003A, 4'hF);
        axi_write(4'h8, 32'h0000_0003, 4'hF);
        check_display(32);

        // Blank via CTRL=0: old pattern until one edge after accept
        S_AXI_AWADDR = 4'h0; S_AXI_WDATA = 32'h0; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        @(negedge clk);
        chk("blank_awready", 32'(S_AXI_AWREADY), 32'd1);
        @(posedge clk); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        model_write(4'h0, 32'h0, 4'hF);
        @(negedge clk);
        chk("seg_before_blank", 32'(ssd_seg != 7'h00), 32'd1);
        @(posedge clk); #1;
        chk("seg_blanked", 32'(ssd_seg), 32'd0);
        axi_write(4'h0, 32'h0000_0001, 4'hF);

        // Read and write of VALUE accepted on the same edge
        S_AXI_AWADDR = 4'h4; S_AXI_WDATA = 32'h0000_0055; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        S_AXI_ARADDR = 4'h4; S_AXI_ARVALID = 1'b1;
        @(negedge clk);
        chk("same_edge_awready", 32'(S_AXI_AWREADY), 32'd1);
        chk("same_edge_arready", 32'(S_AXI_ARREADY), 32'd1);
        @(posedge clk); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        chk("same_edge_rvalid", 32'(S_AXI_RVALID), 32'd1);
        chk("same_edge_old_data", S_AXI_RDATA, 32'h0000_003A);
        model_write(4'h4, 32'h0000_0055, 4'hF);
        @(posedge clk); #1;
        axi_read(4'h4, d); chk("after_write_new_data", d, 32'h0000_0055);

        // Random register traffic against the reference array
        for (int k = 0; k < 40; k++) begin
            ra = {2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 1) == 1) begin
                axi_write(ra, $urandom, 4'($urandom_range(0, 15)));
            end else begin
                axi_read(ra, d);
                chk("rand_readback", d, m_regs[ra[3:2]]);
            end
        end

        // Random display settings with small dividers (DIV=0 included)
        for (int k = 0; k < 5; k++) begin
            axi_write(4'h0, $urandom, 4'hF);
            axi_write(4'h4, $urandom, 4'hF);
            axi_write(4'h8, 32'($urandom_range(0, 5)), 4'hF);
            check_display(30);
        end

        // Reset while a write response is pending
        axi_write(4'h0, 32'h0000_0001, 4'hF);
        axi_write(4'h4, 32'h0000_0012, 4'hF);
        S_AXI_AWADDR = 4'h8; S_AXI_WDATA = 32'h0000_0007; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        chk("pre_reset_bvalid", 32'(S_AXI_BVALID), 32'd1);
        S_AXI_ARESET = 1'b1;
        @(posedge clk); #1;
        chk("reset_drops_bvalid", 32'(S_AXI_BVALID), 32'd0);
        chk("reset_seg", 32'(ssd_seg), 32'd0);
        chk("reset_sel", 32'(ssd_sel), 32'd0);
        S_AXI_ARESET = 1'b0; S_AXI_BREADY = 1'b1;
        model_reset();
        @(posedge clk); #1;
        axi_read(4'h8, d); chk("reset_div_value", d, DIV_RST);
        axi_read(4'h4, d); chk("reset_value_reg", d, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
